// File: rtl/velocity_cell_reader_pkg.sv
// Shared definitions for the per-cell velocity RAM reader: FSM encoding,
// the address of the particle-count word and the {vz, vy, vx} field layout.
package velocity_cell_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_CNT,
    ST_WAIT_CNT,
    ST_STREAM,
    ST_DONE
  } vcr_state_e;

  localparam int VEL_COUNT_ADDR = 0;
  localparam int VEL_FIELD_W    = 32;
  localparam int VX_LSB         = 0;
  localparam int VY_LSB         = 32;
  localparam int VZ_LSB         = 64;

endpackage

// File: rtl/velocity_cell_reader_skid_fifo.sv
// Two-entry synchronous FIFO of {index, data} beats between the RAM read
// port and the output stream; simultaneous push/pop keeps occupancy.
module vel_skid_fifo
  import velocity_cell_reader_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int IDX_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [IDX_W-1:0]  push_idx_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
);

  logic [IDX_W-1:0]  idx_q  [2];
  logic [DATA_W-1:0] data_q [2];
  logic              wr_q, rd_q;
  logic [1:0]        occ_q, occ_d;
  logic              pop_eff;

  assign pop_eff = pop_i && (occ_q != 2'd0);

  always_comb begin
    occ_d = occ_q;
    case ({push_i, pop_eff})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        idx_q[i]  <= '0;
        data_q[i] <= '0;
      end
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      if (push_i) begin
        idx_q[wr_q]  <= push_idx_i;
        data_q[wr_q] <= push_data_i;
        wr_q         <= ~wr_q;
      end
      if (pop_eff) rd_q <= ~rd_q;
      occ_q <= occ_d;
    end
  end

  assign valid_o = (occ_q != 2'd0);
  assign idx_o   = idx_q[rd_q];
  assign data_o  = data_q[rd_q];
  assign occ_o   = occ_q;

endmodule

// File: rtl/velocity_cell_reader.sv
// Read master for one cell velocity RAM: fetches the particle count from
// word 0, then streams words 1..N with credit-based read issue.
module velocity_cell_reader
  import velocity_cell_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
);

  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  vcr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q;
  logic                  err_q;
  logic [ADDR_WIDTH:0]   rd_ptr_q;
  logic [ADDR_WIDTH-1:0] req_idx_q;
  logic                  inflight_q;
  logic                  issue, pop;
  logic [1:0]            fifo_occ;
  logic [2:0]            credit_used, credit_lim;
  logic [ADDR_WIDTH-1:0] raw_count;

  function automatic logic [ADDR_WIDTH-1:0] clamp_count(input logic [ADDR_WIDTH-1:0] raw);
    return (raw > MAX_CNT) ? MAX_CNT : raw;
  endfunction

  assign raw_count   = mem_q[ADDR_WIDTH-1:0];
  assign pop         = out_valid && out_ready;
  assign out_last    = out_valid && (out_index == count_q);
  // A buffered beat plus an in-flight read must never exceed the two FIFO slots.
  assign credit_used = {1'b0, fifo_occ} + {2'b00, inflight_q};
  assign credit_lim  = 3'd2 + {2'b00, pop};

  always_comb begin
    state_d     = state_q;
    mem_rden    = 1'b0;
    mem_address = '0;
    issue       = 1'b0;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_REQ_CNT;
      ST_REQ_CNT: begin
        mem_rden    = 1'b1;
        mem_address = ADDR_WIDTH'(VEL_COUNT_ADDR);
        state_d     = ST_WAIT_CNT;
      end
      ST_WAIT_CNT: state_d = (clamp_count(raw_count) == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM: begin
        if ((rd_ptr_q <= {1'b0, count_q}) && (credit_used < credit_lim)) begin
          issue       = 1'b1;
          mem_rden    = 1'b1;
          mem_address = rd_ptr_q[ADDR_WIDTH-1:0];
        end
        if (pop && out_last) state_d = ST_DONE;
      end
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      err_q      <= 1'b0;
      rd_ptr_q   <= '0;
      req_idx_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (state_q == ST_IDLE && start) err_q <= 1'b0;
      if (state_q == ST_WAIT_CNT) begin
        count_q  <= clamp_count(raw_count);
        err_q    <= (raw_count > MAX_CNT);
        rd_ptr_q <= (ADDR_WIDTH+1)'(1);
      end
      if (issue) begin
        rd_ptr_q  <= rd_ptr_q + (ADDR_WIDTH+1)'(1);
        req_idx_q <= mem_address;
      end
    end
  end

  vel_skid_fifo #(
    .DATA_W (DATA_WIDTH),
    .IDX_W  (ADDR_WIDTH)
  ) u_fifo (
    .clk_i       (clock),
    .rst_i       (rst),
    .push_i      (inflight_q),
    .push_idx_i  (req_idx_q),
    .push_data_i (mem_q),
    .pop_i       (pop),
    .valid_o     (out_valid),
    .idx_o       (out_index),
    .data_o      (out_data),
    .occ_o       (fifo_occ)
  );

  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign particle_count = count_q;
  assign count_err      = err_q;
  assign mem_wren       = 1'b0;
  assign mem_data       = '0;

endmodule

// File: tb/tb_velocity_cell_reader.sv
// Directed bench for velocity_cell_reader with a behavioural 1-cycle RAM.
module tb_velocity_cell_reader;
  import velocity_cell_reader_pkg::*;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clock = 1'b0;
  logic          rst, start, busy, done, count_err;
  logic          mem_rden, mem_wren, out_valid, out_ready, out_last;
  logic [AW-1:0] particle_count, mem_address, out_index;
  logic [DW-1:0] mem_data, out_data;
  logic [DW-1:0] mem_q = '0;

  always #5 clock = ~clock;

  velocity_cell_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
    .clock(clock), .rst(rst), .start(start), .busy(busy), .done(done),
    .particle_count(particle_count), .count_err(count_err),
    .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_data(mem_data), .mem_q(mem_q), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last)
  );

  logic [DW-1:0] ram [PN];
  int cyc = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_rden) mem_q <= ram[mem_address];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_word(input int i);
    logic [DW-1:0] w;
    w = '0;
    w[VX_LSB +: VEL_FIELD_W] = 32'hA000_0000 | i;
    w[VY_LSB +: VEL_FIELD_W] = 32'hB000_0000 | i;
    w[VZ_LSB +: VEL_FIELD_W] = 32'hC000_0000 | i;
    return w;
  endfunction

  // Monitor state
  int            t0 = 0;
  int            ready_mode = 0;
  logic [DW-1:0] bd[$];
  int            bi[$];
  logic          bl[$];
  int            bc[$];
  int            done_n, done_at, busy_low_at, viol, reads, acc, max_out;
  int            rdcnt [PN];
  logic          prev_stall;
  logic [DW-1:0] prev_d;
  logic [AW-1:0] prev_i;

  task automatic mon_clear();
    bd.delete(); bi.delete(); bl.delete(); bc.delete();
    done_n = 0; done_at = -1; busy_low_at = -1;
    viol = 0; reads = 0; acc = 0; max_out = 0; prev_stall = 1'b0;
    for (int a = 0; a < PN; a++) rdcnt[a] = 0;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (!rst) begin
        if (prev_stall && (!out_valid || out_data !== prev_d || out_index !== prev_i)) viol++;
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data;
        prev_i     = out_index;
        if (out_valid && out_ready) begin
          bd.push_back(out_data); bi.push_back(int'(out_index));
          bl.push_back(out_last); bc.push_back(cyc - t0);
          acc++;
        end
        if (mem_rden) begin
          if (int'(mem_address) < PN) rdcnt[mem_address]++;
          if (mem_address != '0) reads++;
        end
        if (reads - acc > max_out) max_out = reads - acc;
        if (done) begin
          done_n++;
          if (done_at < 0) done_at = cyc - t0;
        end
        if (!busy && busy_low_at < 0 && (cyc - t0) > 0) busy_low_at = cyc - t0;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
    end
  end

  task automatic run_pass(input int raw, input int mode, input int pulse_at);
    ram[0] = DW'(raw);
    ready_mode = mode;
    @(negedge clock);
    mon_clear();
    t0 = cyc;
    start = 1'b1;
    for (int k = 0; k < 3000 && done_n == 0; k++) begin
      @(negedge clock);
      start = (pulse_at > 0) && ((cyc - t0) == pulse_at);
    end
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("pass_finished", done_n > 0, 1'b1);
  endtask

  task automatic check_stream(input string tag, input int n);
    int bad;
    chk({tag, "_beats"}, bd.size(), n);
    for (int k = 0; k < bd.size(); k++) begin
      chk({tag, "_data"},  bd[k], mk_word(k + 1));
      chk({tag, "_index"}, bi[k], k + 1);
      chk({tag, "_last"},  bl[k], (k == n - 1));
    end
    bad = 0;
    for (int a = 0; a < PN; a++)
      if (rdcnt[a] != ((a <= n) ? 1 : 0)) bad++;
    chk({tag, "_read_once"}, bad, 0);
    chk({tag, "_max_buffered"}, max_out <= 2, 1'b1);
    chk({tag, "_stall_stable"}, viol, 0);
    chk({tag, "_done_pulses"}, done_n, 1);
  endtask

  initial begin
    for (int a = 0; a < PN; a++) ram[a] = mk_word(a);
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    mon_clear();
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cerr", count_err, 1'b0);
    chk("rst_rden", mem_rden, 1'b0);
    chk("rst_wren", mem_wren, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_pcount", particle_count, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_odata", out_data, 0);
    chk("rst_oindex", out_index, 0);
    chk("rst_mdata", mem_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clock);

    // Count 3, full throughput
    run_pass(3, 0, 0);
    check_stream("n3", 3);
    chk("n3_pcount", particle_count, 3);
    chk("n3_cerr", count_err, 1'b0);
    chk("n3_beat0_cyc", bc.size() > 0 ? bc[0] : -1, 5);
    chk("n3_beat2_cyc", bc.size() > 2 ? bc[2] : -1, 7);
    chk("n3_done_cyc", done_at, 8);
    chk("n3_busy_low", busy_low_at, 9);

    // Count 0
    run_pass(0, 0, 0);
    chk("n0_beats", bd.size(), 0);
    chk("n0_done_cyc", done_at, 3);
    chk("n0_busy_low", busy_low_at, 4);
    chk("n0_pcount", particle_count, 0);

    // Count 5 with out_ready toggling
    run_pass(5, 1, 0);
    check_stream("n5bp", 5);

    // Over-range count clamps and flags
    run_pass(250, 0, 0);
    check_stream("n250", 219);
    chk("n250_pcount", particle_count, 219);
    chk("n250_cerr", count_err, 1'b1);
    chk("n250_done_cyc", done_at, 5 + 219);
    run_pass(3, 0, 0);
    chk("cerr_cleared", count_err, 1'b0);
    run_pass(219, 0, 0);
    chk("n219_pcount", particle_count, 219);
    chk("n219_cerr", count_err, 1'b0);

    // Reset in the middle of a stream
    ram[0] = DW'(5);
    ready_mode = 0;
    @(negedge clock);
    mon_clear();
    t0 = cyc;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 50 && acc < 2; k++) @(negedge clock);
    chk("mid_two_beats", acc >= 2, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_rden", mem_rden, 1'b0);
    chk("mid_rst_odata", out_data, 0);
    chk("mid_rst_oindex", out_index, 0);
    chk("mid_rst_pcount", particle_count, 0);
    chk("mid_rst_last", out_last, 1'b0);
    repeat (2) @(negedge clock);
    rst = 1'b0;
    done_n = 0;
    repeat (10) @(negedge clock);
    chk("mid_rst_no_done", done_n, 0);
    run_pass(5, 0, 0);
    check_stream("replay", 5);

    // start pulsed while busy
    run_pass(3, 0, 3);
    check_stream("busy_start", 3);
    chk("busy_start_done_cyc", done_at, 8);
    chk("busy_start_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/velocity_cell_reader.md
# velocity_cell_reader

Sequencing read master for one per-cell velocity memory (single-port RAM, 1-cycle read latency, address 0 = particle count, words 1..N = `{vz, vy, vx}`). On `start` it fetches the count word, then streams particles 1..N out on a valid/ready interface with full throughput under back-pressure. It sits between a cell velocity RAM and the motion-update / velocity-cache consumer, and owns that RAM's address/rden/wren pins while busy.

## Interface
- `DATA_WIDTH`, 96: velocity word width, `{vz, vy, vx}`, 32 bits each.
- `ADDR_WIDTH`, 8: RAM address width.
- `PARTICLE_NUM`, 220: RAM depth in words; maximum legal count is `PARTICLE_NUM-1`.
- `clock`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin one cell read pass; sampled only in IDLE.
- `busy`  out  1  high from the cycle after accepted `start` until return to IDLE.
- `done`  out  1  one-cycle pulse at end of pass.
- `particle_count`  out  ADDR_WIDTH  count latched from word 0, clamped.
- `count_err`  out  1  sticky: raw count exceeded `PARTICLE_NUM-1`; cleared on next accepted `start`.
- `mem_address`  out  ADDR_WIDTH  RAM address.
- `mem_rden`  out  1  RAM read enable.
- `mem_wren`  out  1  constant 0.
- `mem_data`  out  DATA_WIDTH  constant 0.
- `mem_q`  in  DATA_WIDTH  RAM read data, valid 1 cycle after `mem_rden`.
- `out_valid`  out  1  stream beat valid.
- `out_ready`  in  1  consumer accepts beat.
- `out_data`  out  DATA_WIDTH  velocity word.
- `out_index`  out  ADDR_WIDTH  RAM address (1..N) the beat came from.
- `out_last`  out  1  beat is particle N.

## Operation
- Reset values: state IDLE; `busy`, `done`, `count_err`, `mem_rden`, `out_valid`, `out_last` = 0; `particle_count`, `mem_address`, `out_data`, `out_index` = 0; FIFO empty; in-flight flag 0.
- States: IDLE -> REQ_CNT (on `start`) -> WAIT_CNT -> STREAM (count ≥ 1) or DONE (count = 0) -> IDLE.
- REQ_CNT: `mem_address`=0, `mem_rden`=1.
- WAIT_CNT: latch `mem_q[ADDR_WIDTH-1:0]`; if it exceeds `PARTICLE_NUM-1`, latch `PARTICLE_NUM-1` and set `count_err`.
- STREAM: read pointer `rd_ptr` runs 1..count. Issue read (`mem_rden`=1, `mem_address`=`rd_ptr`) when `rd_ptr` ≤ count and `occ + inflight - pop < 2`, where `occ` is FIFO occupancy, `inflight` is a read issued last cycle, and `pop` = `out_valid && out_ready`. Returned `mem_q` is written next edge into a 2-entry FIFO with its index.
- Exit STREAM when the beat with `out_last`=1 is accepted. DONE lasts one cycle, `done`=1, then IDLE.
- `start` while busy: ignored. `out_valid` never drops before acceptance; `out_data`/`out_index` are stable while `out_valid && !out_ready`.
- Simultaneous FIFO push and pop: occupancy unchanged, order preserved.
- `rst` mid-pass: immediate return to reset values, FIFO flushed, no `done`.

## Timing
- With `start` sampled at the end of cycle 0: REQ_CNT cycle 1, WAIT_CNT cycle 2, first read in cycle 3, first `out_valid` in cycle 5.
- With `out_ready` held high: one beat per cycle, last beat in cycle 4+N, `done` in cycle 5+N, `busy` low from cycle 6+N.
- Count 0: DONE in cycle 3 (`done`=1), no beats, `busy` low from cycle 4.
- Back-pressure: never more than 2 beats buffered plus in-flight; no RAM read is ever dropped.

## Structure
- The shared package holds the state encoding, `VEL_COUNT_ADDR` = 0, and the 32-bit field offsets of `{vz, vy, vx}`.
- One sub-module: `vel_skid_fifo`, a 2-entry synchronous FIFO of `{index, data}` with `occ` output.
- The FSM, read pointer and credit logic live in the top module.

## Test plan
- Count=3, words 1..3 = 0x…01/02/03, `out_ready`=1 -> beats at cycles 5,6,7 with index 1,2,3, `out_last` on index 3, `done` at cycle 8.
- Count=0 -> no `out_valid`, `done` at cycle 3, `particle_count`=0.
- Count=5, `out_ready` toggling 1,0,0,1,… -> all 5 beats in order, data stable while stalled, never more than 2 buffered, each address read exactly once.
- Count=250 with `PARTICLE_NUM`=220 -> `particle_count`=219, `count_err`=1, 219 beats; next `start` clears `count_err`.
- `rst` asserted mid-stream after 2 beats -> all outputs at reset values next cycle, no `done`; a new `start` replays from index 1.
- `start` pulsed while busy -> ignored, and the pass completes unchanged.
